// File: rtl/varredura_matriz.sv
// Column-scan controller for a 7x5 LED matrix: snapshots five column patterns per
// frame and lights one column at a time, with an all-off gap between columns.
module varredura_matriz #(
    parameter int DIV   = 4,
    parameter int BLANK = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [6:0] col0,
    input  logic [6:0] col1,
    input  logic [6:0] col2,
    input  logic [6:0] col3,
    input  logic [6:0] col4,
    output logic [2:0] sel,
    output logic [4:0] col_n,
    output logic [6:0] lin,
    output logic       frame_done
);

    localparam logic [15:0] DIV_LAST   = 16'(DIV - 1);
    localparam logic [15:0] BLANK_LAST = 16'(BLANK - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHOW,
        ST_BLANK
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [2:0]  idx_reg, idx_next;
    logic        load;

    logic [6:0]  col_in [5];
    logic [6:0]  shadow_reg [5];

    logic [2:0]  sel_reg, sel_next;
    logic [4:0]  col_n_reg, col_n_next;
    logic [6:0]  lin_reg, lin_next;
    logic        frame_done_reg, frame_done_next;
    logic        show_next;

    assign col_in[0] = col0;
    assign col_in[1] = col1;
    assign col_in[2] = col2;
    assign col_in[3] = col3;
    assign col_in[4] = col4;

    always_comb begin
        state_next      = state_reg;
        cnt_next        = 16'(cnt_reg + 16'd1);
        idx_next        = idx_reg;
        load            = 1'b0;
        frame_done_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (en) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                load       = 1'b1;
                idx_next   = '0;
                cnt_next   = '0;
                state_next = ST_SHOW;
            end
            ST_SHOW: begin
                if (cnt_reg == DIV_LAST) begin
                    cnt_next   = '0;
                    state_next = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (cnt_reg == BLANK_LAST) begin
                    cnt_next = '0;
                    if (idx_reg == 3'd4) begin
                        // en is only honoured here and in IDLE, so a frame always completes
                        frame_done_next = 1'b1;
                        state_next      = en ? ST_LOAD : ST_IDLE;
                    end else begin
                        idx_next   = 3'(idx_reg + 3'd1);
                        state_next = ST_SHOW;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output registers are loaded from next-state values so they line up with the state.
    always_comb begin
        show_next = (state_next == ST_SHOW);
        sel_next  = (state_next == ST_SHOW || state_next == ST_BLANK) ? idx_next : 3'd0;
        lin_next  = '0;
        if (show_next) lin_next = load ? col_in[0] : shadow_reg[idx_next];
    end

    for (genvar gi = 0; gi < 5; gi++) begin : g_col_drv
        assign col_n_next[gi] = ~(show_next && (idx_next == 3'(gi)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            idx_reg        <= '0;
            sel_reg        <= '0;
            col_n_reg      <= 5'b11111;
            lin_reg        <= '0;
            frame_done_reg <= 1'b0;
            for (int i = 0; i < 5; i++) shadow_reg[i] <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            sel_reg        <= sel_next;
            col_n_reg      <= col_n_next;
            lin_reg        <= lin_next;
            frame_done_reg <= frame_done_next;
            if (load) begin
                for (int i = 0; i < 5; i++) shadow_reg[i] <= col_in[i];
            end
        end
    end

    assign sel        = sel_reg;
    assign col_n      = col_n_reg;
    assign lin        = lin_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_varredura_matriz.sv
// Bench for varredura_matriz: a frame-position model checks two instances
// (DIV=4/BLANK=1 and DIV=1/BLANK=1) every cycle, plus directed literal checks.
module tb_varredura_matriz;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [6:0] cols [5];

    logic [2:0] sel_o  [2];
    logic [4:0] coln_o [2];
    logic [6:0] lin_o  [2];
    logic       done_o [2];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit check_on = 0;
    bit steady = 0;

    // Model state: frame position (0 = LOAD cycle) and the snapshot on display.
    bit         m_active [2] = '{0, 0};
    bit         m_done   [2] = '{0, 0};
    int         m_pos    [2] = '{0, 0};
    logic [6:0] m_snap   [2][5];
    int         last_done [2] = '{-1, -1};

    always #5 clk = ~clk;

    varredura_matriz #(.DIV(4), .BLANK(1)) dut (
        .clk(clk), .rst(rst), .en(en),
        .col0(cols[0]), .col1(cols[1]), .col2(cols[2]), .col3(cols[3]), .col4(cols[4]),
        .sel(sel_o[0]), .col_n(coln_o[0]), .lin(lin_o[0]), .frame_done(done_o[0])
    );

    varredura_matriz #(.DIV(1), .BLANK(1)) dut_c (
        .clk(clk), .rst(rst), .en(en),
        .col0(cols[0]), .col1(cols[1]), .col2(cols[2]), .col3(cols[3]), .col4(cols[4]),
        .sel(sel_o[1]), .col_n(coln_o[1]), .lin(lin_o[1]), .frame_done(done_o[1])
    );

    function automatic int div_of(input int u);
        return (u == 0) ? 4 : 1;
    endfunction

    function automatic int period_of(input int u);
        return 1 + 5 * (div_of(u) + 1);
    endfunction

    task automatic check(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [inst %0d] cycle %0d: got %0h, expected %0h", nm, u, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                m_active[u] = 0;
                m_pos[u]    = 0;
                m_done[u]   = 0;
                for (int k = 0; k < 5; k++) m_snap[u][k] = '0;
            end else if (!m_active[u]) begin
                m_done[u] = 0;
                if (en) begin
                    m_active[u] = 1;
                    m_pos[u]    = 0;
                end
            end else begin
                if (m_pos[u] == 0)
                    for (int k = 0; k < 5; k++) m_snap[u][k] = cols[k];
                if (m_pos[u] == period_of(u) - 1) begin
                    m_done[u]   = 1;
                    m_pos[u]    = 0;
                    m_active[u] = en;
                end else begin
                    m_done[u] = 0;
                    m_pos[u]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_on) begin
            for (int u = 0; u < 2; u++) begin
                logic [4:0] e_coln;
                logic [6:0] e_lin;
                int         e_sel;
                bit         chk_sel;
                e_coln  = 5'b11111;
                e_lin   = '0;
                e_sel   = 0;
                chk_sel = 1;
                if (m_active[u] && m_pos[u] == 0) begin
                    chk_sel = 0;
                end else if (m_active[u]) begin
                    int q, k;
                    q     = m_pos[u] - 1;
                    k     = q / (div_of(u) + 1);
                    e_sel = k;
                    if ((q % (div_of(u) + 1)) < div_of(u)) begin
                        e_coln = ~(5'b00001 << k);
                        e_lin  = m_snap[u][k];
                    end
                end
                check("col_n", u, 32'(coln_o[u]), 32'(e_coln));
                check("lin", u, 32'(lin_o[u]), 32'(e_lin));
                if (chk_sel) check("sel", u, 32'(sel_o[u]), 32'(e_sel));
                check("frame_done", u, 32'(done_o[u]), 32'(m_done[u]));
                check("one_col_low", u, 32'($countones(~coln_o[u]) <= 1), 32'd1);
            end
        end
    end

    // Frame period measured between consecutive frame_done pulses while en stays high.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!steady) begin
                last_done[u] = -1;
            end else if (done_o[u] === 1'b1) begin
                if (last_done[u] >= 0)
                    check("frame_period", u, 32'(cyc - last_done[u]), (u == 0) ? 32'd26 : 32'd11);
                last_done[u] = cyc;
            end
        end
    end

    task automatic wait_col(input logic [4:0] pat, input string nm);
        int n = 0;
        while (coln_o[0] !== pat && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(nm, 0, 32'(n < 200), 32'd1);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (done_o[0] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(nm, 0, 32'(n < 200), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        cols[0] = 7'h01; cols[1] = 7'h02; cols[2] = 7'h04; cols[3] = 7'h08; cols[4] = 7'h10;
        repeat (2) @(negedge clk);
        check("rst_col_n", 0, 32'(coln_o[0]), 32'h1F);
        check("rst_lin", 0, 32'(lin_o[0]), 32'h0);
        check("rst_sel", 0, 32'(sel_o[0]), 32'h0);
        check("rst_frame_done", 0, 32'(done_o[0]), 32'h0);
        $display("reset values checked at cycle %0d", cyc);
        check_on = 1;
        steady   = 1;
        rst      = 1'b0;

        @(negedge clk);
        check("load_blank", 0, 32'(coln_o[0]), 32'h1F);
        @(negedge clk);
        check("first_lit_col_n", 0, 32'(coln_o[0]), 32'h1E);
        check("first_lit_lin", 0, 32'(lin_o[0]), 32'h01);
        check("first_lit_sel", 0, 32'(sel_o[0]), 32'h0);
        $display("first column lit two edges after reset release");
        repeat (60) @(negedge clk);

        wait_col(5'b11101, "wait_col1_snap");
        cols[2] = 7'h7F;
        $display("col2 changed to 7f while column 1 lit, cycle %0d", cyc);
        wait_col(5'b11011, "wait_col2_old");
        check("snap_old_col2", 0, 32'(lin_o[0]), 32'h04);
        wait_done("wait_done_snap");
        wait_col(5'b11011, "wait_col2_new");
        check("snap_new_col2", 0, 32'(lin_o[0]), 32'h7F);
        $display("snapshot isolation sequence done, cycle %0d", cyc);

        steady = 0;
        wait_col(5'b11101, "wait_col1_endrop");
        en = 1'b0;
        $display("en dropped while column 1 lit, cycle %0d", cyc);
        wait_done("wait_done_endrop");
        repeat (10) @(negedge clk);
        check("idle_col_n", 0, 32'(coln_o[0]), 32'h1F);
        check("idle_sel", 0, 32'(sel_o[0]), 32'h0);
        check("idle_col_n_corner", 1, 32'(coln_o[1]), 32'h1F);
        en = 1'b1;
        wait_col(5'b11110, "wait_restart");
        check("restart_lin", 0, 32'(lin_o[0]), 32'h01);
        $display("scan resumed after en returned, cycle %0d", cyc);

        wait_col(5'b10111, "wait_col3_rst");
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_col_n", 0, 32'(coln_o[0]), 32'h1F);
        check("rst_mid_sel", 0, 32'(sel_o[0]), 32'h0);
        check("rst_mid_frame_done", 0, 32'(done_o[0]), 32'h0);
        rst = 1'b0;
        steady = 1;
        @(negedge clk);
        @(negedge clk);
        check("after_rst_col_n", 0, 32'(coln_o[0]), 32'h1E);
        $display("reset mid-show recovered from column 0, cycle %0d", cyc);

        repeat (80) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
